// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch block.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } if_state_e;

  localparam logic [31:0] PC_INCR    = 32'd4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Memory, redirect and decode-side signals of the fetch unit.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: small in-order FIFO of {instr, pc}; flush wins over push/pop.
module fetch_buffer
  import instruction_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push_i,
  input  fetch_entry_t       wdata_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output fetch_entry_t       rdata_o,
  output logic [CNT_W-1:0]   count_o
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  fetch_entry_t [FIFO_DEPTH-1:0] mem_q;
  logic [PW-1:0]                 rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]              count_q, count_d;

  assign count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory requests into a 2-entry buffer.
// Optional IFETCH_STATS_EN adds a fetch_count output of decode handshakes.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  instruction_fetch_if.master bus
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]         fetch_count
`endif
);

  if_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d, addr_q, addr_d;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head, wentry;
  logic             redirect, accept, push, pop;

  assign redirect = bus.redirect_valid;

  // Outside FETCH a request is already in flight and must be held until ack.
  assign bus.imem_req  = reset_n && ((state_q != FETCH) || (count < CNT_W'(FIFO_DEPTH)));
  assign bus.imem_addr = (state_q == FETCH) ? pc_q : addr_q;

  assign accept = bus.imem_req && bus.imem_ack;
  assign push   = accept && (state_q != DRAIN) && !redirect;
  assign pop    = bus.instr_valid && bus.instr_ready && !redirect;

  assign wentry.instr = bus.imem_rdata;
  assign wentry.pc    = bus.imem_addr;

  fetch_buffer u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .flush_i (redirect),
    .rdata_o (head),
    .count_o (count)
  );

  assign bus.instr_valid = (count != '0);
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    if (state_q == FETCH && bus.imem_req) addr_d = pc_q;
    if (redirect)  pc_d = align_pc(bus.redirect_pc);
    else if (push) pc_d = pc_q + PC_INCR;
    case (state_q)
      FETCH:   if (bus.imem_req && !bus.imem_ack) state_d = redirect ? DRAIN : WAIT;
      WAIT:    if (bus.imem_ack) state_d = FETCH;
               else if (redirect) state_d = DRAIN;
      DRAIN:   if (bus.imem_ack) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_count_q <= '0;
    else if (bus.instr_valid && bus.instr_ready) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: scripted memory/decode stimulus, scoreboard on decode handshakes.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  instruction_fetch_if bus();
`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_count;
`endif

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef IFETCH_STATS_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int acc_cnt  = 0;
  int acc_base = 0;
  fetch_entry_t exp_q[$];

  int mem_lat  = 0;
  bit mem_hold = 1'b0;
  int wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] ins, input logic [31:0] pc);
    fetch_entry_t e;
    e.instr = ins;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Memory model: word = addr + 0x1000_0000, ack after mem_lat wait cycles.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n) begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
      end else begin
        if (bus.imem_ack) wait_cnt = 0;
        if (bus.imem_req && !mem_hold && wait_cnt >= mem_lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = bus.imem_addr + 32'h1000_0000;
        end else begin
          bus.imem_ack = 1'b0;
          if (bus.imem_req) wait_cnt++;
        end
      end
    end
  end

  // Monitor: pop and compare on every decode handshake.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (reset_n && bus.imem_req && bus.imem_ack) acc_cnt++;
    if (reset_n && bus.instr_valid && bus.instr_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h expected no entry", bus.instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", bus.instr, e.instr);
        chk("sb_pc", bus.instr_pc, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_0000);

    // Zero-wait streaming with decode always ready
    exp_push(32'h1000_0000, 32'h0);
    exp_push(32'h1000_0004, 32'h4);
    exp_push(32'h1000_0008, 32'h8);
    cyc(); reset_n = 1'b1;
    smp(); chk("a_c0_req", 32'(bus.imem_req), 32'd1);
           chk("a_c0_addr", bus.imem_addr, 32'h0);
           chk("a_c0_valid", 32'(bus.instr_valid), 32'd0);
    cyc(); smp(); chk("a_c1_addr", bus.imem_addr, 32'h4);
                  chk("a_c1_valid", 32'(bus.instr_valid), 32'd1);
    cyc(); smp(); chk("a_c2_addr", bus.imem_addr, 32'h8);
                  chk("a_c2_valid", 32'(bus.instr_valid), 32'd1);
    cyc(); smp(); chk("a_c3_pc", bus.instr_pc, 32'h8);
    cyc(); bus.instr_ready = 1'b0;
    smp(); chk("a_c4_pc", bus.instr_pc, 32'hC);

    // Asynchronous reset in the middle of a request
    #1 reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus.imem_req), 32'd0);
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_instr_pc", bus.instr_pc, 32'h0);
    chk("a_sb_drained", 32'(exp_q.size()), 32'd0);

    // Decode stalled: buffer fills with two entries and requests stop
    cyc();
    acc_base = acc_cnt;
    cyc(); reset_n = 1'b1;
    smp(); chk("b_c0_addr", bus.imem_addr, 32'h0);
    cyc(); smp(); chk("b_c1_addr", bus.imem_addr, 32'h4);
                  chk("b_c1_req", 32'(bus.imem_req), 32'd1);
    cyc(); smp(); chk("b_c2_req", 32'(bus.imem_req), 32'd0);
                  chk("b_c2_pc", bus.instr_pc, 32'h0);
    cyc(); smp(); chk("b_c3_req", 32'(bus.imem_req), 32'd0);
    cyc(); smp(); chk("b_c4_req", 32'(bus.imem_req), 32'd0);
                  chk("b_c4_pc", bus.instr_pc, 32'h0);
                  chk("b_accepts", 32'(acc_cnt - acc_base), 32'd2);

    // Redirect while waiting on pc 8: drain the stale response
    exp_push(32'h1000_0000, 32'h0);
    exp_push(32'h1000_0004, 32'h4);
    cyc(); mem_hold = 1'b1; bus.instr_ready = 1'b1;
    cyc(); smp(); chk("c_c6_addr", bus.imem_addr, 32'h8);
    cyc(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0103;
    smp(); chk("c_c7_req", 32'(bus.imem_req), 32'd1);
           chk("c_c7_valid", 32'(bus.instr_valid), 32'd0);
    cyc(); bus.redirect_valid = 1'b0;
    smp(); chk("c_drain_req", 32'(bus.imem_req), 32'd1);
           chk("c_drain_addr", bus.imem_addr, 32'h8);
           chk("c_drain_valid", 32'(bus.instr_valid), 32'd0);
    cyc(); smp(); chk("c_drain2_addr", bus.imem_addr, 32'h8);
    exp_push(32'h1000_0100, 32'h100);
    cyc(); mem_hold = 1'b0;
    smp(); chk("c_stale_valid", 32'(bus.instr_valid), 32'd0);
    cyc(); smp(); chk("c_target_addr", bus.imem_addr, 32'h100);
                  chk("c_target_valid", 32'(bus.instr_valid), 32'd0);
    cyc(); smp(); chk("c_c12_valid", 32'(bus.instr_valid), 32'd1);

    // Redirect coinciding with an ack: acked word dropped
    cyc(); bus.instr_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_2000;
    smp(); chk("d_head_pc", bus.instr_pc, 32'h104);
    cyc(); bus.redirect_valid = 1'b0; bus.instr_ready = 1'b1;
    smp(); chk("d_target_addr", bus.imem_addr, 32'h2000);
           chk("d_flushed", 32'(bus.instr_valid), 32'd0);

    // Slow memory: request held stable for the three wait cycles
    exp_push(32'h1000_2000, 32'h2000);
    exp_push(32'h1000_2004, 32'h2004);
    cyc(); mem_lat = 3;
    smp(); chk("e_c15_addr", bus.imem_addr, 32'h2004);
    for (int k = 0; k < 3; k++) begin
      cyc(); smp();
      chk("e_hold_req", 32'(bus.imem_req), 32'd1);
      chk("e_hold_addr", bus.imem_addr, 32'h2004);
      chk("e_hold_valid", 32'(bus.instr_valid), 32'd0);
    end
    cyc(); mem_lat = 0;
    smp(); chk("e_one_entry", bus.instr_pc, 32'h2004);

    // Address wrap past 32'hFFFF_FFFC
    exp_push(32'h0FFF_FFF8, 32'hFFFF_FFF8);
    exp_push(32'h0FFF_FFFC, 32'hFFFF_FFFC);
    exp_push(32'h1000_0000, 32'h0);
    cyc(); bus.instr_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    smp(); chk("f_head_pc", bus.instr_pc, 32'h2008);
    cyc(); bus.redirect_valid = 1'b0; bus.instr_ready = 1'b1;
    smp(); chk("f_addr_fff8", bus.imem_addr, 32'hFFFF_FFF8);
    cyc(); smp(); chk("f_addr_fffc", bus.imem_addr, 32'hFFFF_FFFC);
    cyc(); smp(); chk("f_addr_wrap", bus.imem_addr, 32'h0);
    cyc(); smp(); chk("f_pc_wrap", bus.instr_pc, 32'h0);
    cyc(); bus.instr_ready = 1'b0;
    repeat (2) cyc();
    chk("f_sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef IFETCH_STATS_EN
    chk("stats_fetch_count", fetch_count, 32'd8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port imem_req, output, 1, instruction memory request valid.
REQ-005 SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-006 SHALL have port imem_ack, input, 1, memory accepts the request; imem_rdata valid in the same cycle.
REQ-007 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-008 SHALL have port redirect_valid, input, 1, branch/jump redirect strobe.
REQ-009 SHALL have port redirect_pc, input, 32, redirect target; bits [1:0] ignored and treated as 0.
REQ-010 SHALL have port instr_valid, output, 1, instr/instr_pc hold a valid entry for the decode stage.
REQ-011 SHALL have port instr, output, 32, instruction word for decode.
REQ-012 SHALL have port instr_pc, output, 32, address of instr.
REQ-013 SHALL have port instr_ready, input, 1, decode consumes the head entry when instr_valid && instr_ready.

Function
REQ-014 SHALL keep a fetch PC, incremented by 4 on every accepted (imem_req && imem_ack) non-discarded request; 32-bit wrap from 32'hFFFF_FFFC to 0.
REQ-015 SHALL buffer fetched words in a 2-entry in-order FIFO of {instr, pc}; instr_valid = FIFO not empty; outputs show the head.
REQ-016 SHALL allow at most one outstanding request, issuing only when FIFO count plus outstanding requests < 2.
REQ-017 SHALL hold imem_req high and imem_addr stable from assertion until imem_ack; imem_req never drops before ack.
REQ-018 SHALL use states FETCH (request may be issued), WAIT (request outstanding, no ack yet) and DRAIN (outstanding request is stale, response to be discarded).
REQ-019 Transitions: FETCH->WAIT on request without ack; WAIT->FETCH on ack; WAIT->DRAIN on redirect without ack; DRAIN->FETCH on ack, with data discarded.
REQ-020 On redirect_valid: flush the FIFO, load PC with redirect_pc, and take priority over a simultaneous push, pop or PC increment.
REQ-021 SHALL discard ack data arriving in the redirect cycle; no DRAIN is entered in that case.
REQ-022 SHALL issue the redirect target fetch in the cycle after the redirect, or after DRAIN completes.
REQ-023 SHALL support push and pop in the same cycle with count unchanged; no push can target a full FIFO, per REQ-016.
REQ-024 Latency: zero-wait memory gives instr_valid one cycle after the accepting ack; sustained throughput is 1 instruction/cycle with instr_ready held high.

Reset
REQ-025 On reset_n low, all state SHALL clear immediately: PC=RESET_PC, state FETCH, FIFO empty, imem_req=0, instr_valid=0, instr=0, instr_pc=0, imem_addr=RESET_PC.
REQ-026 SHALL assert imem_req in the first clock cycle after reset_n deasserts.
REQ-027 Reset mid-request SHALL abandon the request; the memory is reset by the same reset_n.

Configuration
REQ-028 With IFETCH_STATS_EN defined, SHALL add output fetch_count, 32 bits, incremented on each instr_valid && instr_ready handshake, reset to 0 and wrapping.
REQ-029 Without IFETCH_STATS_EN, SHALL omit the fetch_count port and its logic entirely.

Structure
REQ-030 Shared package SHALL hold the state enum (FETCH/WAIT/DRAIN), PC increment constant 4, and FIFO depth 2.
REQ-031 The FIFO SHALL be a sub-module fetch_buffer (2-entry, 64-bit data, push/pop/flush, count).

Verification
REQ-032 Reset release, zero-wait memory, instr_ready=1 -> imem_addr sequence 0,4,8; instr_valid from cycle 2 with instr_pc 0,4,8 back-to-back.
REQ-033 instr_ready=0 for 5 cycles -> exactly 2 entries buffered (pc 0,4); imem_req low; no third request issued.
REQ-034 Redirect to 32'h0000_0103 while WAIT at pc 8 -> DRAIN; stale ack dropped; next imem_addr=32'h0000_0100; FIFO empty meanwhile.
REQ-035 Redirect in the same cycle as ack -> acked data not enqueued; next request at the redirect target the following cycle.
REQ-036 Memory ack delayed 3 cycles -> imem_addr stable and imem_req high throughout; one entry enqueued.
REQ-037 PC 32'hFFFF_FFFC fetched -> next imem_addr 0; with IFETCH_STATS_EN, fetch_count equals the handshake count.
